// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   ADDR_W_DEF / INSTR_W_DEF : default address and instruction widths
//   fetch_state_e            : fetch FSM encoding (RUN, DRAIN)
//   NOP                      : all-zero instruction word
package if_fetch_unit_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    // RUN   : normal fetching.
    // DRAIN : a redirect hit an outstanding request; wait for its ack and
    //         throw the returned word away before fetching from the target.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    localparam logic [INSTR_W_DEF-1:0] NOP = '0;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Prefetch queue: small synchronous FIFO between instruction memory and decode.
// Ports:
//   clk_i, rst_n : clock, synchronous active-low reset
//   push, data   : write data at the tail
//   pop          : remove the head entry
//   flush        : empty the queue; wins over push and pop
//   head         : entry at the head (meaningless while empty)
//   count        : current occupancy, 0..DEPTH
//   empty, full  : occupancy flags
module if_fetch_unit_fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           data,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; only the pointers
    // and count define validity, which keeps the array a plain RAM.
    always_ff @(posedge clk_i) begin
        if (push && !flush) mem[wr_ptr] <= data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end of the 5-stage pipeline.
// Owns the fetch PC, runs a req/ack handshake to instruction memory, buffers
// returned words in a prefetch queue and presents {instr, pc+4} to decode.
// Ports:
//   clk_i, rst_n                  : clock, synchronous active-low reset
//   imem_req_o, imem_addr_o       : registered fetch request and word address
//   imem_ack_i, imem_data_i       : request completion and fetched word
//   stall_i                       : decode cannot accept the head this cycle
//   redirect_i, redirect_pc_i     : flush and restart fetch at a new target
//   id_valid_o, id_instr_o,
//   id_pc_add_4_o                 : head entry offered to decode
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_n,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               id_valid_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic [ADDR_W-1:0]  id_pc_add_4_o
);

    localparam int                ENTRY_W    = INSTR_W + ADDR_W;
    localparam int                CNT_W      = $clog2(QDEPTH) + 1;
    localparam logic [CNT_W-1:0]  QDEPTH_C   = CNT_W'(QDEPTH);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_e       state;
    logic [ADDR_W-1:0]  target;           // redirect target held across DRAIN
    logic [ADDR_W-1:0]  redirect_target;
    logic               ack;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   q_count;
    logic [CNT_W-1:0]   count_next;
    logic               q_empty;
    logic               q_full;

    // Acks are only meaningful while a request is actually outstanding.
    assign ack  = imem_req_o && imem_ack_i;
    // Words returning in DRAIN belong to the abandoned path and are dropped.
    assign push = ack && (state == ST_RUN) && (!q_full || pop);

    assign id_valid_o      = !q_empty && !redirect_i;
    assign pop             = id_valid_o && !stall_i;
    assign redirect_target = redirect_pc_i & ALIGN_MASK;

    assign id_instr_o    = q_empty ? '0 : head[ENTRY_W-1 -: INSTR_W];
    assign id_pc_add_4_o = q_empty ? '0 : head[ADDR_W-1:0];

    // Occupancy after this edge; a new request is only issued if the word it
    // returns is guaranteed a slot, so an outstanding request never overflows.
    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch
        // is inferred.
        count_next = q_count;
        if (push) count_next = count_next + CNT_W'(1);
        if (pop)  count_next = count_next - CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_PC;
            target      <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (redirect_i) begin
                        if (imem_req_o && !imem_ack_i) begin
                            // Request in flight cannot be withdrawn.
                            state  <= ST_DRAIN;
                            target <= redirect_target;
                        end else begin
                            imem_req_o  <= 1'b1;
                            imem_addr_o <= redirect_target;
                        end
                    end else begin
                        if (ack) imem_addr_o <= imem_addr_o + ADDR_STEP;
                        imem_req_o <= (count_next < QDEPTH_C);
                    end
                end
                ST_DRAIN: begin
                    imem_req_o <= 1'b1;
                    if (ack) begin
                        state       <= ST_RUN;
                        imem_addr_o <= redirect_i ? redirect_target : target;
                    end else if (redirect_i) begin
                        target <= redirect_target;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    if_fetch_unit_fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .data  ({imem_data_i, imem_addr_o + ADDR_STEP}),
        .head  (head),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a latency-programmable memory model,
// a scoreboard of expected decode entries, a cycle table for the streaming /
// stall phase and hand-written redirect, wrap and reset sequences.
module tb_if_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_add_4_o;

    if_fetch_unit dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_add_4_o (id_pc_add_4_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // memory model / bench state
    int  lat      = 0;
    int  wait_cnt = 0;
    bit  drain    = 1'b0;

    // values sampled during the most recent step
    logic        s_valid, s_req, s_ack;
    logic [31:0] s_instr, s_pc4, s_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, sample and score
    // before the rising edge, then confirm handshake stability after it.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
        logic spurious;
        exp_t e;
        @(negedge clk_i);
        s_ack       = imem_req_o && (wait_cnt >= lat);
        spurious    = !imem_req_o && st;   // stray ack while idle must be ignored
        imem_ack_i  = s_ack || spurious;
        imem_data_i = s_ack ? (imem_addr_o >> 2) : 32'hDEAD_BEEF;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        #2;
        s_valid = id_valid_o;
        s_instr = id_instr_o;
        s_pc4   = id_pc_add_4_o;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;

        if (s_valid && !st) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr", s_instr, e.instr);
                check("sb_pc4", s_pc4, e.pc4);
            end
        end
        if (rd) begin
            check("valid_during_redirect", s_valid, 1'b0);
            exp_q.delete();
        end
        if (s_ack) begin
            if (drain)    drain = 1'b0;
            else if (!rd) exp_q.push_back('{instr: imem_data_i, pc4: s_addr + 32'd4});
        end else if (rd && s_req) begin
            drain = 1'b1;
        end

        @(posedge clk_i);
        #1;
        if (s_req && s_ack) wait_cnt = 0;
        else if (s_req)     wait_cnt++;
        else                wait_cnt = 0;
        if (s_req && !s_ack) begin
            check("hs_req_hold", imem_req_o, 1'b1);
            check("hs_addr_hold", imem_addr_o, s_addr);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_i);
        rst_n = 1'b0;
        imem_ack_i = 1'b0; imem_data_i = '0;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        exp_q.delete();
        drain = 1'b0;
        wait_cnt = 0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
            check("rst_req", imem_req_o, 1'b0);
            check("rst_addr", imem_addr_o, 32'h0);
            check("rst_valid", id_valid_o, 1'b0);
            check("rst_instr", id_instr_o, 32'h0);
            check("rst_pc4", id_pc_add_4_o, 32'h0);
        end
        @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t tbl[12];
        bit   found;

        // cycle k (k=1 is the cycle after the first edge out of reset), zero-wait memory
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'd0, 32'h00};
        tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'd0, 32'h04};
        tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'd1, 32'h08};
        tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'd2, 32'h0C};
        tbl[4]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'd2, 32'h0C};
        tbl[5]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'd2, 32'h0C};
        tbl[6]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'd2, 32'h0C};
        tbl[7]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'd2, 32'h0C};
        tbl[8]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'd2, 32'h0C};
        tbl[9]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'd3, 32'h10};
        tbl[10] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'd4, 32'h14};
        tbl[11] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'd5, 32'h18};

        // reset, streaming at one per cycle, stall with full queue
        do_reset(2);
        lat = 0;
        for (int k = 0; k < 12; k++) begin
            step(tbl[k].stall, 1'b0, 32'h0);
            check($sformatf("tbl%0d_req", k), s_req, tbl[k].req);
            check($sformatf("tbl%0d_addr", k), s_addr, tbl[k].addr);
            check($sformatf("tbl%0d_valid", k), s_valid, tbl[k].valid);
            check($sformatf("tbl%0d_instr", k), s_instr, tbl[k].instr);
            check($sformatf("tbl%0d_pc4", k), s_pc4, tbl[k].pc4);
        end

        // redirect while a slow request to 0x8 is outstanding -> DRAIN
        do_reset(2);
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (s_req && s_addr == 32'h8) found = 1'b1;
        end
        check("t4_req_at_8", found, 1'b1);
        step(1'b0, 1'b1, 32'h43);
        check("t4_redirect_addr_hold", s_addr, 32'h8);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0);
            check("t4_drain_addr", s_addr, 32'h8);
            check("t4_drain_valid", s_valid, 1'b0);
            if (s_ack) found = 1'b1;
        end
        check("t4_drain_acked", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (s_req) found = 1'b1;
        end
        check("t4_req_after_drain", found, 1'b1);
        check("t4_target_addr", s_addr, 32'h40);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (s_valid) found = 1'b1;
        end
        check("t4_first_valid", found, 1'b1);
        check("t4_first_instr", s_instr, 32'h10);
        check("t4_first_pc4", s_pc4, 32'h44);

        // redirect in the same cycle as an ack with a valid head
        lat = 0;
        repeat (4) step(1'b0, 1'b0, 32'h0);
        check("t5_pre_valid", s_valid, 1'b1);
        check("t5_pre_ack", s_ack, 1'b1);
        step(1'b0, 1'b1, 32'h105);
        check("t5_ack_with_redirect", s_ack, 1'b1);
        step(1'b0, 1'b0, 32'h0);
        check("t5_empty_after", s_valid, 1'b0);
        check("t5_req", s_req, 1'b1);
        check("t5_addr", s_addr, 32'h104);
        repeat (3) step(1'b0, 1'b0, 32'h0);

        // PC wrap 0xFFFF_FFFC -> 0
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (s_ack && s_addr == 32'hFFFF_FFFC) found = 1'b1;
        end
        check("t6_reach_top", found, 1'b1);
        step(1'b0, 1'b0, 32'h0);
        check("t6_wrap_addr", s_addr, 32'h0);
        repeat (3) step(1'b0, 1'b0, 32'h0);

        // reset with a request outstanding
        lat = 5;
        repeat (2) step(1'b0, 1'b0, 32'h0);
        check("t6_pending_req", s_req && !s_ack, 1'b1);
        do_reset(1);
        lat = 0;
        step(1'b0, 1'b0, 32'h0);
        check("t6_restart_req", s_req, 1'b1);
        check("t6_restart_addr", s_addr, 32'h0);
        repeat (4) step(1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end for the 5-stage pipelined CPU, directly upstream of the IF/ID pipeline register.
- Owns the program counter and runs a req/ack handshake to a multi-cycle instruction memory.
- Buffers fetched words in a small prefetch queue and presents {instruction, PC+4} to decode.
- Honours decode stall (load-use hazard) and branch redirect/flush from a later stage.

Parameters:
- ADDR_W, 32, PC / memory address width.
- INSTR_W, 32, instruction word width.
- QDEPTH, 2, prefetch queue entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk_i  in  1  clock.
- rst_n  in  1  reset. Synchronous, active-low; the only reset. All registers clear on the clk_i edge where rst_n==0.
- imem_req_o  out  1  fetch request; registered.
- imem_addr_o  out  ADDR_W  fetch address; registered, word aligned.
- imem_ack_i  in  1  request completes; imem_data_i is valid this cycle.
- imem_data_i  in  INSTR_W  fetched instruction.
- stall_i  in  1  decode cannot accept this cycle.
- redirect_i  in  1  branch taken / flush.
- redirect_pc_i  in  ADDR_W  new fetch target; bits [1:0] ignored (treated as 0).
- id_valid_o  out  1  head entry valid for decode.
- id_instr_o  out  INSTR_W  head instruction.
- id_pc_add_4_o  out  ADDR_W  head entry address + 4.

Behaviour:
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, queue empty, id_valid_o=0, id_instr_o=0, id_pc_add_4_o=0 while empty, fetch PC=RESET_PC, state=RUN.
- Handshake: once imem_req_o=1, req and addr stay stable until the cycle with imem_ack_i=1. A request is never withdrawn. imem_ack_i while req=0 is ignored.
- Issue rule: at each edge, req_next=1 iff state==RUN, no redirect, and count_next + 0 < QDEPTH.
  - count_next is the occupancy after this cycle's push/pop.
  - On an ack, a new request may follow back-to-back: req stays 1 and addr advances by 4.
  - Zero-wait memory (ack every cycle) sustains 1 instruction/cycle.
- Push: ack in RUN writes {imem_data_i, imem_addr_o+4} to the queue tail. Fetch PC += 4, with 32-bit wrap (0xFFFF_FFFC -> 0).
- Pop: id_valid_o && !stall_i at the edge.
  - id_valid_o = (count!=0) && !redirect_i.
  - Outputs show the head entry; hold stable while stalled.
- Simultaneous push and pop while full is legal; count is unchanged.
- FSM states:
  - RUN: normal operation.
  - DRAIN: a redirect arrived with a request outstanding. Keep req/addr until ack, discard that data, then load the redirect PC into addr and return to RUN.
- Redirect, highest priority:
  - Queue flushed that edge; no pop counted.
  - Saved target = redirect_pc_i & ~3.
  - If req=0, or req=1 with ack the same cycle: next cycle req=1 at the target, state RUN.
  - If req=1 with no ack: state -> DRAIN.
  - A further redirect during DRAIN overwrites the saved target.
- Stall has no effect on fetch other than through queue fullness.
- Reset mid-operation: everything returns to reset values. The outstanding request is abandoned, and the memory must also be reset.

Decomposition:
- Shared package holds:
  - ADDR_W and INSTR_W defaults.
  - The fetch FSM state encoding (RUN, DRAIN).
  - A NOP constant (32'h0) for bench use.
- One natural sub-module: fetch_queue, a synchronous FIFO.
  - Inputs: push, pop, flush, data.
  - Outputs: head, count, empty/full.
  - Flush has priority over push and pop.

Test Plan:
1. rst_n=0 for 2 cycles, RESET_PC=0 -> req=0, id_valid_o=0. First edge after release: req=1, addr=0x0.
2. Ack every cycle, stall_i=0, memory returns addr>>2 -> addr 0,4,8,... Decode sees instr 0,1,2,... with pc_add_4 0x4,0x8,0xC, one per cycle from cycle 2.
3. stall_i=1 for 5 cycles mid-stream -> queue fills to 2, req drops to 0, id outputs frozen. On release, sequence resumes with no loss or duplication.
4. Ack delayed 3 cycles; redirect_i=1 with redirect_pc_i=0x43 one cycle after req at 0x8 -> addr holds 0x8 until ack, data discarded. Next req addr=0x40; first valid is instr@0x40 with pc_add_4=0x44.
5. Redirect in the same cycle as ack with valid head -> id_valid_o=0 that cycle, queue empty next cycle, next req addr=target, no DRAIN.
6. PC at 0xFFFF_FFFC with ack -> next addr 0x0000_0000. rst_n=0 while req pending -> req=0 and addr=RESET_PC after that edge.
